// File: rtl/modulation_segment_serializer.sv
// Double-buffered symbol capture; streams NUM_SEG segment words per symbol
// on a valid/ready sample port, with symbol count and sticky drop flag.
module modulation_segment_serializer #(
  parameter int NUM_SEG = 10,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SEG*DATA_W-1:0] segments_in,
  input  logic                      symbol_valid,
  output logic                      symbol_ready,
  output logic [DATA_W-1:0]         sample_out,
  output logic                      sample_valid,
  input  logic                      sample_ready,
  output logic                      sample_last,
  output logic [CNT_W-1:0]          sym_count,
  output logic                      overflow
);

  localparam int IDX_W = $clog2(NUM_SEG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEG - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  typedef logic [NUM_SEG-1:0][DATA_W-1:0] sym_t;

  state_e           state_q, state_d;
  sym_t             pend_data_q, pend_data_d;
  sym_t             act_data_q, act_data_d;
  logic             pend_valid_q, pend_valid_d;
  logic [IDX_W-1:0] seg_idx_q, seg_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic act_valid;
  logic xfer;
  logic is_last;

  assign act_valid = (state_q == STREAM);
  assign xfer      = act_valid && sample_ready;
  assign is_last   = (seg_idx_q == LAST_IDX);

  always_comb begin
    state_d      = state_q;
    pend_data_d  = pend_data_q;
    pend_valid_d = pend_valid_q;
    act_data_d   = act_data_q;
    seg_idx_d    = seg_idx_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;

    // accept and pending->active load are mutually exclusive on pend_valid
    if (symbol_valid && !pend_valid_q) begin
      pend_data_d  = sym_t'(segments_in);
      pend_valid_d = 1'b1;
    end
    if (symbol_valid && pend_valid_q) begin
      ovf_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          act_data_d   = pend_data_q;
          pend_valid_d = 1'b0;
          seg_idx_d    = '0;
          state_d      = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (is_last) begin
            cnt_d     = cnt_q + CNT_W'(1);
            seg_idx_d = '0;
            if (pend_valid_q) begin
              act_data_d   = pend_data_q;
              pend_valid_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            seg_idx_d = seg_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pend_data_q  <= '0;
      pend_valid_q <= 1'b0;
      act_data_q   <= '0;
      seg_idx_q    <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_data_q  <= pend_data_d;
      pend_valid_q <= pend_valid_d;
      act_data_q   <= act_data_d;
      seg_idx_q    <= seg_idx_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
    end
  end

  assign symbol_ready = !pend_valid_q;
  assign sample_valid = act_valid;
  assign sample_out   = act_valid ? act_data_q[seg_idx_q] : '0;
  assign sample_last  = act_valid && is_last;
  assign sym_count    = cnt_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_modulation_segment_serializer.sv
// Directed bench for modulation_segment_serializer.
// Counter narrowed to 8 bits so the wraparound is reachable in a short run.
module tb_modulation_segment_serializer;

  localparam int NUM_SEG = 10;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 8;

  logic                      clk;
  logic                      reset;
  logic [NUM_SEG*DATA_W-1:0] segments_in;
  logic                      symbol_valid;
  logic                      symbol_ready;
  logic [DATA_W-1:0]         sample_out;
  logic                      sample_valid;
  logic                      sample_ready;
  logic                      sample_last;
  logic [CNT_W-1:0]          sym_count;
  logic                      overflow;

  modulation_segment_serializer #(
    .NUM_SEG(NUM_SEG),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .segments_in (segments_in),
    .symbol_valid(symbol_valid),
    .symbol_ready(symbol_ready),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .sample_last (sample_last),
    .sym_count   (sym_count),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              l;
    int                c;
  } xfer_t;

  xfer_t             xq[$];
  int                cyc = 0;
  int                total = 0;
  int                bad = 0;
  int                stall_checks = 0;
  int                stall_bad = 0;
  bit                prev_stall = 0;
  logic [DATA_W-1:0] prev_out;
  logic              prev_last;
  logic [CNT_W-1:0]  exp_cnt = '0;

  always @(posedge clk) cyc++;

  // record transfers and hold-stability at the falling edge
  always @(negedge clk) begin
    if (reset) begin
      if (prev_stall) begin
        stall_checks++;
        if (sample_out !== prev_out || sample_last !== prev_last ||
            sample_valid !== 1'b1)
          stall_bad++;
      end
      if (sample_valid && sample_ready)
        xq.push_back('{sample_out, sample_last, cyc});
      prev_stall = sample_valid && !sample_ready;
      prev_out   = sample_out;
      prev_last  = sample_last;
    end else begin
      prev_stall = 0;
    end
  end

  function automatic logic [NUM_SEG*DATA_W-1:0] mk_sym(
    input logic [DATA_W-1:0] base);
    logic [NUM_SEG*DATA_W-1:0] s;
    s = '0;
    for (int k = 0; k < NUM_SEG; k++)
      s[k*DATA_W +: DATA_W] = base + DATA_W'(k);
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      if (!sample_valid && symbol_ready) begin
        ok = 1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    symbol_valid = 1'b0;
    sample_ready = 1'b1;
    segments_in = '0;
    repeat (3) step();
    total++;
    if (sample_valid !== 1'b0 || sample_out !== '0 || sample_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: got v=%b o=%h l=%b need 0/0/0",
               sample_valid, sample_out, sample_last);
    end
    total++;
    if (symbol_ready !== 1'b1 || sym_count !== '0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b cnt=%h ovf=%b need 1/0/0",
               symbol_ready, sym_count, overflow);
    end
    reset = 1'b1;
    exp_cnt = '0;
    step();
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] exp_d;
    int acc;
    bit ok;
    bit gap_ok;
    xq.delete();
    sample_ready = 1'b1;
    total++;
    if (symbol_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_rdy: got %b need 1", symbol_ready);
    end
    segments_in = mk_sym(32'h1000_0000);
    symbol_valid = 1'b1;
    step();
    acc = cyc;
    symbol_valid = 1'b0;
    total++;
    if (sample_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_lat1: valid got %b need 0", sample_valid);
    end
    step();
    total++;
    if (sample_valid !== 1'b1 || sample_out !== 32'h1000_0000 ||
        sample_last !== 1'b0) begin
      bad++;
      $display("FAIL single_lat2: got v=%b o=%h l=%b need 1/10000000/0",
               sample_valid, sample_out, sample_last);
    end
    wait_drain(40, ok);
    exp_cnt = exp_cnt + 1'b1;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL single_drain: timeout got busy need idle");
    end
    total++;
    if (xq.size() !== NUM_SEG) begin
      bad++;
      $display("FAIL single_len: got %0d need %0d", xq.size(), NUM_SEG);
    end
    for (int i = 0; i < NUM_SEG; i++) begin
      exp_d = 32'h1000_0000 + 32'(i);
      total++;
      if (i >= xq.size()) begin
        bad++;
        $display("FAIL single_seq[%0d]: got none need %h", i, exp_d);
      end else if (xq[i].d !== exp_d || xq[i].l !== (i == NUM_SEG - 1)) begin
        bad++;
        $display("FAIL single_seq[%0d]: got %h/%b need %h/%b",
                 i, xq[i].d, xq[i].l, exp_d, (i == NUM_SEG - 1));
      end
    end
    gap_ok = (xq.size() > 0) && (xq[0].c == acc + 1);
    for (int i = 1; i < xq.size(); i++)
      if (xq[i].c != xq[0].c + i) gap_ok = 0;
    total++;
    if (!gap_ok) begin
      bad++;
      $display("FAIL single_timing: got first=%0d need %0d, no gaps",
               (xq.size() > 0) ? xq[0].c : -1, acc + 1);
    end
    total++;
    if (sym_count !== exp_cnt) begin
      bad++;
      $display("FAIL single_cnt: got %h need %h", sym_count, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] exp_d;
    bit ok;
    bit gap_ok;
    xq.delete();
    sample_ready = 1'b1;
    segments_in = mk_sym(32'h2000_0000);
    symbol_valid = 1'b1;
    step();
    symbol_valid = 1'b0;
    total++;
    if (symbol_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_rdy0: got %b need 0", symbol_ready);
    end
    step();
    total++;
    if (symbol_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_rdy1: got %b need 1", symbol_ready);
    end
    segments_in = mk_sym(32'h2100_0000);
    symbol_valid = 1'b1;
    step();
    symbol_valid = 1'b0;
    wait_drain(60, ok);
    exp_cnt = exp_cnt + 2'd2;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL b2b_drain: timeout got busy need idle");
    end
    for (int i = 0; i < 2 * NUM_SEG; i++) begin
      exp_d = (i < NUM_SEG ? 32'h2000_0000 : 32'h2100_0000) + 32'(i % NUM_SEG);
      total++;
      if (i >= xq.size()) begin
        bad++;
        $display("FAIL b2b_seq[%0d]: got none need %h", i, exp_d);
      end else if (xq[i].d !== exp_d || xq[i].l !== (i % NUM_SEG == NUM_SEG - 1)) begin
        bad++;
        $display("FAIL b2b_seq[%0d]: got %h/%b need %h/%b", i, xq[i].d,
                 xq[i].l, exp_d, (i % NUM_SEG == NUM_SEG - 1));
      end
    end
    gap_ok = (xq.size() == 2 * NUM_SEG);
    for (int i = 1; i < xq.size(); i++)
      if (xq[i].c != xq[0].c + i) gap_ok = 0;
    total++;
    if (!gap_ok) begin
      bad++;
      $display("FAIL b2b_gap: got n=%0d with gaps need 20 contiguous", xq.size());
    end
    total++;
    if (sym_count !== exp_cnt || overflow !== 1'b0) begin
      bad++;
      $display("FAIL b2b_cnt: got cnt=%h ovf=%b need %h/0",
               sym_count, overflow, exp_cnt);
    end
  endtask

  task automatic test_drop();
    logic [DATA_W-1:0] exp_d;
    bit ok;
    xq.delete();
    sample_ready = 1'b1;
    segments_in = mk_sym(32'h3000_0000);
    symbol_valid = 1'b1;
    step();
    symbol_valid = 1'b0;
    step();
    segments_in = mk_sym(32'h3100_0000);
    symbol_valid = 1'b1;
    step();
    total++;
    if (symbol_ready !== 1'b0) begin
      bad++;
      $display("FAIL drop_rdy: got %b need 0", symbol_ready);
    end
    segments_in = mk_sym(32'h3200_0000);
    step();
    symbol_valid = 1'b0;
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL drop_ovf: got %b need 1", overflow);
    end
    wait_drain(60, ok);
    exp_cnt = exp_cnt + 2'd2;
    total++;
    if (!ok || xq.size() !== 2 * NUM_SEG) begin
      bad++;
      $display("FAIL drop_len: got ok=%b n=%0d need 1/20", ok, xq.size());
    end
    for (int i = 0; i < 2 * NUM_SEG; i++) begin
      exp_d = (i < NUM_SEG ? 32'h3000_0000 : 32'h3100_0000) + 32'(i % NUM_SEG);
      total++;
      if (i >= xq.size()) begin
        bad++;
        $display("FAIL drop_seq[%0d]: got none need %h", i, exp_d);
      end else if (xq[i].d !== exp_d) begin
        bad++;
        $display("FAIL drop_seq[%0d]: got %h need %h", i, xq[i].d, exp_d);
      end
    end
    total++;
    if (overflow !== 1'b1 || sym_count !== exp_cnt) begin
      bad++;
      $display("FAIL drop_sticky: got ovf=%b cnt=%h need 1/%h",
               overflow, sym_count, exp_cnt);
    end
  endtask

  task automatic test_stall();
    logic [31:0] pat;
    logic [DATA_W-1:0] exp_d;
    int sc0;
    int sb0;
    bit ok;
    pat = 32'b1001_0110_0011_1010_0100_1101_1000_1011;
    xq.delete();
    sc0 = stall_checks;
    sb0 = stall_bad;
    sample_ready = 1'b1;
    segments_in = mk_sym(32'h4000_0000);
    symbol_valid = 1'b1;
    step();
    symbol_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (xq.size() >= NUM_SEG) break;
      sample_ready = pat[i % 32];
      step();
    end
    sample_ready = 1'b1;
    wait_drain(40, ok);
    exp_cnt = exp_cnt + 1'b1;
    total++;
    if (!ok || xq.size() !== NUM_SEG) begin
      bad++;
      $display("FAIL stall_len: got ok=%b n=%0d need 1/10", ok, xq.size());
    end
    for (int i = 0; i < NUM_SEG; i++) begin
      exp_d = 32'h4000_0000 + 32'(i);
      total++;
      if (i >= xq.size()) begin
        bad++;
        $display("FAIL stall_seq[%0d]: got none need %h", i, exp_d);
      end else if (xq[i].d !== exp_d || xq[i].l !== (i == NUM_SEG - 1)) begin
        bad++;
        $display("FAIL stall_seq[%0d]: got %h/%b need %h/%b",
                 i, xq[i].d, xq[i].l, exp_d, (i == NUM_SEG - 1));
      end
    end
    total++;
    if (stall_checks - sc0 < 3 || stall_bad != sb0) begin
      bad++;
      $display("FAIL stall_hold: got stalls=%0d unstable=%0d need >=3/0",
               stall_checks - sc0, stall_bad - sb0);
    end
    total++;
    if (overflow !== 1'b1 || sym_count !== exp_cnt) begin
      bad++;
      $display("FAIL stall_cnt: got ovf=%b cnt=%h need 1/%h",
               overflow, sym_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] exp_d;
    bit found;
    bit ok;
    sample_ready = 1'b1;
    segments_in = mk_sym(32'h5000_0000);
    symbol_valid = 1'b1;
    step();
    symbol_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (sample_valid && sample_out === 32'h5000_0004) begin
        found = 1;
        break;
      end
      step();
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL rmid_reach: got no seg4 need 50000004");
    end
    #2;
    reset = 1'b0;
    #1;
    exp_cnt = '0;
    total++;
    if (sample_valid !== 1'b0 || sample_out !== '0 || sample_last !== 1'b0 ||
        symbol_ready !== 1'b1 || sym_count !== '0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL rmid_async: got v=%b o=%h l=%b r=%b c=%h f=%b need 0/0/0/1/0/0",
               sample_valid, sample_out, sample_last, symbol_ready,
               sym_count, overflow);
    end
    repeat (2) step();
    reset = 1'b1;
    xq.delete();
    segments_in = mk_sym(32'h6000_0000);
    symbol_valid = 1'b1;
    step();
    symbol_valid = 1'b0;
    wait_drain(40, ok);
    exp_cnt = exp_cnt + 1'b1;
    total++;
    if (!ok || xq.size() !== NUM_SEG) begin
      bad++;
      $display("FAIL rmid_len: got ok=%b n=%0d need 1/10", ok, xq.size());
    end
    for (int i = 0; i < NUM_SEG; i++) begin
      exp_d = 32'h6000_0000 + 32'(i);
      total++;
      if (i >= xq.size()) begin
        bad++;
        $display("FAIL rmid_seq[%0d]: got none need %h", i, exp_d);
      end else if (xq[i].d !== exp_d) begin
        bad++;
        $display("FAIL rmid_seq[%0d]: got %h need %h", i, xq[i].d, exp_d);
      end
    end
    total++;
    if (sym_count !== exp_cnt) begin
      bad++;
      $display("FAIL rmid_cnt: got %h need %h", sym_count, exp_cnt);
    end
  endtask

  task automatic test_wrap();
    int need;
    int n;
    bit acc;
    bit ok;
    need = (1 << CNT_W) - 1 - int'(exp_cnt);
    n = 0;
    sample_ready = 1'b1;
    for (int g = 0; g < 6000 && n < need; g++) begin
      segments_in = mk_sym(32'h7000_0000 + 32'(n * 16));
      symbol_valid = symbol_ready;
      acc = symbol_valid && symbol_ready;
      step();
      if (acc) n++;
    end
    symbol_valid = 1'b0;
    wait_drain(60, ok);
    total++;
    if (!ok || n != need || sym_count !== 8'hFF) begin
      bad++;
      $display("FAIL wrap_max: got ok=%b n=%0d cnt=%h need 1/%0d/ff",
               ok, n, sym_count, need);
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL wrap_ovf: got %b need 0", overflow);
    end
    segments_in = mk_sym(32'h7F00_0000);
    symbol_valid = 1'b1;
    step();
    symbol_valid = 1'b0;
    wait_drain(40, ok);
    total++;
    if (!ok || sym_count !== 8'h00) begin
      bad++;
      $display("FAIL wrap_zero: got ok=%b cnt=%h need 1/00", ok, sym_count);
    end
    xq.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_drop();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
